bus_config_ctrl: RTL and testbench

Configuration front-end for the serial system bus. It consumes the debounced single-cycle button pulses, mode_switch and switch_array, and walks the operator through master, slave, address, data and burst selection. On commit it writes the chosen transaction descriptor into the per-master configuration registers that the bus masters read when an operation is launched. It sits between the button debouncers and the master interfaces inside Top.

---
 rtl/bus_config_ctrl.sv | 125 ++++++++++++
 tb/tb_bus_config_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bus_config_ctrl.sv
// bus_config_ctrl: operator-driven FSM that builds a transaction descriptor and commits it to M1/M2 config registers.
// Optional CFG_BUSY_LOCK_EN holds COMMIT until the selected master's busy input drops.
module bus_config_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 4,
  parameter int NUM_SLAVES  = 3
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   mode_switch,
  input  logic                   next_pulse,
  input  logic                   inc_pulse,
  input  logic [11:0]            switch_array,
  input  logic                   m1_busy,
  input  logic                   m2_busy,
  output logic [1:0]             m1_slave,
  output logic [1:0]             m2_slave,
  output logic [ADDR_WIDTH-1:0]  m1_addr,
  output logic [ADDR_WIDTH-1:0]  m2_addr,
  output logic [DATA_WIDTH-1:0]  m1_data,
  output logic [DATA_WIDTH-1:0]  m2_data,
  output logic [BURST_WIDTH-1:0] m1_burst,
  output logic [BURST_WIDTH-1:0] m2_burst,
  output logic [1:0]             cfg_update,
  output logic [2:0]             cfg_state
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SEL_MASTER = 3'd1;
  localparam logic [2:0] SEL_SLAVE  = 3'd2;
  localparam logic [2:0] SEL_ADDR   = 3'd3;
  localparam logic [2:0] SEL_DATA   = 3'd4;
  localparam logic [2:0] SEL_BURST  = 3'd5;
  localparam logic [2:0] COMMIT     = 3'd6;

  logic [2:0]             state_q, state_d;
  logic                   master_q, master_d;
  logic [1:0]             slave_q, slave_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [1:0]             update_q;
  logic                   hold, wr;

`ifdef CFG_BUSY_LOCK_EN
  assign hold = master_q ? m2_busy : m1_busy;
`else
  logic unused_busy;
  assign unused_busy = m1_busy ^ m2_busy;
  assign hold = 1'b0;
`endif

  assign wr = (state_q == COMMIT) && !hold;

  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    slave_d  = slave_q;
    addr_d   = addr_q;
    data_d   = data_q;
    burst_d  = burst_q;
    if (state_q == COMMIT) begin
      state_d = hold ? COMMIT : IDLE;
    end else if (mode_switch) begin
      state_d = IDLE;
      slave_d = '0;
      addr_d  = '0;
      data_d  = '0;
      burst_d = '0;
    end else if (next_pulse) begin
      state_d = state_q + 3'd1;
      slave_d = (state_q == IDLE) ? 2'd0 : slave_q;
      addr_d  = (state_q == SEL_ADDR) ? switch_array[ADDR_WIDTH-1:0] : addr_q;
      data_d  = (state_q == SEL_DATA) ? switch_array[DATA_WIDTH-1:0] : data_q;
      burst_d = (state_q == SEL_BURST) ? switch_array[BURST_WIDTH-1:0] : burst_q;
    end else if (inc_pulse) begin
      master_d = (state_q == SEL_MASTER) ? ~master_q : master_q;
      slave_d  = (state_q != SEL_SLAVE) ? slave_q :
                 (slave_q == 2'(NUM_SLAVES - 1)) ? 2'd0 : slave_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= IDLE;
      master_q <= 1'b0;
      slave_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      burst_q  <= '0;
      update_q <= '0;
      m1_slave <= '0;
      m2_slave <= '0;
      m1_addr  <= '0;
      m2_addr  <= '0;
      m1_data  <= '0;
      m2_data  <= '0;
      m1_burst <= '0;
      m2_burst <= '0;
    end else begin
      state_q  <= state_d;
      master_q <= master_d;
      slave_q  <= slave_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      burst_q  <= burst_d;
      update_q <= {wr && master_q, wr && !master_q};
      if (wr && !master_q) begin
        m1_slave <= slave_q;
        m1_addr  <= addr_q;
        m1_data  <= data_q;
        m1_burst <= burst_q;
      end
      if (wr && master_q) begin
        m2_slave <= slave_q;
        m2_addr  <= addr_q;
        m2_data  <= data_q;
        m2_burst <= burst_q;
      end
    end
  end

  assign cfg_update = update_q;
  assign cfg_state  = state_q;
endmodule

// File: tb/tb_bus_config_ctrl.sv
// tb_bus_config_ctrl: directed self-checking bench for bus_config_ctrl (covers CFG_BUSY_LOCK_EN when defined).
module tb_bus_config_ctrl;
  logic        clock = 1'b0;
  logic        rst, mode_switch, next_pulse, inc_pulse, m1_busy, m2_busy;
  logic [11:0] switch_array;
  logic [1:0]  m1_slave, m2_slave, cfg_update;
  logic [11:0] m1_addr, m2_addr;
  logic [7:0]  m1_data, m2_data;
  logic [3:0]  m1_burst, m2_burst;
  logic [2:0]  cfg_state;
  int tests = 0;
  int fails = 0;

  bus_config_ctrl dut (
    .clock(clock), .rst(rst), .mode_switch(mode_switch), .next_pulse(next_pulse),
    .inc_pulse(inc_pulse), .switch_array(switch_array), .m1_busy(m1_busy), .m2_busy(m2_busy),
    .m1_slave(m1_slave), .m2_slave(m2_slave), .m1_addr(m1_addr), .m2_addr(m2_addr),
    .m1_data(m1_data), .m2_data(m2_data), .m1_burst(m1_burst), .m2_burst(m2_burst),
    .cfg_update(cfg_update), .cfg_state(cfg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic step(input logic n, input logic i);
    next_pulse = n;
    inc_pulse  = i;
    @(negedge clock);
    next_pulse = 1'b0;
    inc_pulse  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mode_switch = 1'b0; next_pulse = 1'b0; inc_pulse = 1'b0;
    m1_busy = 1'b0; m2_busy = 1'b0; switch_array = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", 32'(cfg_state), 0);
    chk("reset_update", 32'(cfg_update), 0);
    chk("reset_m1_addr", 32'(m1_addr), 0);
    chk("reset_m2_data", 32'(m2_data), 0);

    // plain M1 commit, all fields 11
    switch_array = 12'd11;
    repeat (6) step(1, 0);
    chk("t1_in_commit", 32'(cfg_state), 6);
    chk("t1_no_early_update", 32'(cfg_update), 0);
    chk("t1_no_early_write", 32'(m1_addr), 0);
    step(1, 0);
    chk("t1_back_idle", 32'(cfg_state), 0);
    chk("t1_update", 32'(cfg_update), 1);
    chk("t1_m1_slave", 32'(m1_slave), 0);
    chk("t1_m1_addr", 32'(m1_addr), 11);
    chk("t1_m1_data", 32'(m1_data), 11);
    chk("t1_m1_burst", 32'(m1_burst), 11);
    chk("t1_m2_untouched", 32'(m2_addr), 0);
    tick();
    chk("t1_update_pulse_end", 32'(cfg_update), 0);

    // M2 commit with slave 2
    step(1, 0); step(0, 1); step(1, 0); step(0, 1); step(0, 1);
    step(1, 0);
    switch_array = 12'd12;  step(1, 0);
    switch_array = 12'd35;  step(1, 0);
    switch_array = 12'd5;   step(1, 0);
    tick();
    chk("t2_update", 32'(cfg_update), 2);
    chk("t2_m2_slave", 32'(m2_slave), 2);
    chk("t2_m2_addr", 32'(m2_addr), 12);
    chk("t2_m2_data", 32'(m2_data), 35);
    chk("t2_m2_burst", 32'(m2_burst), 5);
    chk("t2_m1_addr_kept", 32'(m1_addr), 11);
    chk("t2_m1_data_kept", 32'(m1_data), 11);

    // slave wraps 0->1->2->0->1; shadow master still M2
    step(1, 0); step(1, 0);
    repeat (4) step(0, 1);
    chk("t3_sel_slave", 32'(cfg_state), 2);
    switch_array = 12'd7;
    repeat (4) step(1, 0);
    tick();
    chk("t3_update", 32'(cfg_update), 2);
    chk("t3_m2_slave_wrap", 32'(m2_slave), 1);
    chk("t3_m2_addr", 32'(m2_addr), 7);

    // abort in SEL_DATA
    switch_array = 12'd99;
    step(1, 0); step(0, 1); step(1, 0); step(1, 0); step(1, 0);
    chk("t4_sel_data", 32'(cfg_state), 4);
    mode_switch = 1'b1;
    tick();
    chk("t4_abort_idle", 32'(cfg_state), 0);
    chk("t4_abort_no_update", 32'(cfg_update), 0);
    step(1, 0);
    chk("t4_next_ignored", 32'(cfg_state), 0);
    step(0, 1);
    chk("t4_inc_ignored", 32'(cfg_state), 0);
    mode_switch = 1'b0;
    tick();
    chk("t4_m1_addr_kept", 32'(m1_addr), 11);
    chk("t4_m2_addr_kept", 32'(m2_addr), 7);
    chk("t4_still_no_update", 32'(cfg_update), 0);

    // next+inc together in SEL_MASTER: inc dropped, master stays M1
    step(1, 0);
    step(1, 1);
    chk("t5_both_to_slave", 32'(cfg_state), 2);
    switch_array = 12'd3;
    repeat (4) step(1, 0);
    tick();
    chk("t5_update_m1", 32'(cfg_update), 1);
    chk("t5_m1_addr", 32'(m1_addr), 3);
    chk("t5_m1_burst", 32'(m1_burst), 3);
    chk("t5_m2_addr_kept", 32'(m2_addr), 7);

    // reset in SEL_ADDR clears everything
    step(1, 0); step(1, 0); step(1, 0);
    chk("t5_sel_addr", 32'(cfg_state), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_state", 32'(cfg_state), 0);
    chk("t5_rst_m1_addr", 32'(m1_addr), 0);
    chk("t5_rst_m2_addr", 32'(m2_addr), 0);
    chk("t5_rst_m2_slave", 32'(m2_slave), 0);
    chk("t5_rst_m2_data", 32'(m2_data), 0);

    // busy handling at commit
    switch_array = 12'd9;
    m1_busy = 1'b1;
    repeat (6) step(1, 0);
    chk("t6_in_commit", 32'(cfg_state), 6);
`ifdef CFG_BUSY_LOCK_EN
    mode_switch = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t6_hold_state", 32'(cfg_state), 6);
      chk("t6_hold_no_update", 32'(cfg_update), 0);
    end
    chk("t6_hold_no_write", 32'(m1_addr), 0);
    mode_switch = 1'b0;
    m1_busy = 1'b0;
    tick();
`else
    tick();
`endif
    chk("t6_idle", 32'(cfg_state), 0);
    chk("t6_update", 32'(cfg_update), 1);
    chk("t6_m1_addr", 32'(m1_addr), 9);
    chk("t6_m1_data", 32'(m1_data), 9);
    m1_busy = 1'b0;
    tick();
    chk("t6_update_end", 32'(cfg_update), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
